// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmitter. Each frame carries one byte: a start bit (0), eight data
//   bits LSB first, an optional parity bit, and one or two stop bits (1). The
//   bit period comes from an internal divider of FREQ/BAUDRATE clk cycles.
//   Host logic hands over bytes with a valid/ready handshake.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, a parity bit follows the data bits and the parity_odd
//     input is present (0 = even parity, 1 = odd parity).
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   parity_odd  parity select (only with UART_TX_PARITY_EN)
//   tx_data     byte to send, sampled when tx_valid && tx_ready
//   tx_valid    host has a byte pending
//   tx_ready    block can accept a byte
//   tx          serial line, idle high
//   tx_busy     a frame is on the line
//   tx_done     one-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int unsigned BAUDRATE  = 19200,
  parameter int unsigned FREQ      = 50_000_000,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef UART_TX_PARITY_EN
  input  logic       parity_odd,
`endif
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // A divide ratio below 1 would make no sense; clamp so the divider is legal.
  localparam int unsigned BIT_CYC = (FREQ / BAUDRATE > 0) ? FREQ / BAUDRATE : 1;
  localparam int unsigned DIV_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BIT_CYC - 1);
  // Any STOP_BITS value other than 2 gives a single stop bit.
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_tick;
`ifdef UART_TX_PARITY_EN
  // The shift register is consumed during DATA, so parity needs its own copy.
  logic [7:0]        data_q, data_d;
`endif

  assign bit_tick = (state_q != S_IDLE) && (div_q == DIV_MAX);

  // Bit-period divider: parked at 0 in IDLE so every frame starts with a full
  // first bit, measured from the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (state_q == S_IDLE || bit_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      data_q  <= data_d;
`endif
    end
  end

  // Next-state logic. The line level is computed one step ahead so that tx
  // leaves a flop and never has a combinational path from tx_valid.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that skips an
    // assignment would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    data_d  = data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx_valid && ready_q) begin
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          data_d  = tx_data;
`endif
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;       // start bit goes out on the accept edge
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_tick) begin
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = (^data_q) ^ parity_odd;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
`endif
          end else begin
            // The bit after the current one sits at [1] before the shift.
            shreg_d = {1'b0, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_tick) begin
          if (!TWO_STOP || stop_q) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
